mips_pipe_ctrl: RTL
===================

# mips_pipe_ctrl

Parametrised pipelined control unit for the 5-stage MIPS core. It decodes the ID-stage opcode and carries the control word and destination-register address through ID/EX, EX/MEM and MEM/WB registers. It resolves j/jal/beq/bne in EX, with bne fully resolved, and generates flushes, load-use stalls and EX-operand forwarding selects. It also keeps saturating stall and flush counters for the performance test bench.

## Interface
- `REG_ADDR_W`, default 5: register-address width.
- `LINK_REG`, default 31: jal destination register.
- `CNT_W`, default 16: width of the performance counters.
- `clk` input, 1: rising-edge clock.
- `rst_n` input, 1: reset, asynchronous, active-low.
- `id_opcode` input, 6: opcode of the instruction in ID.
- `id_rs`, `id_rt`, `id_rd` input, REG_ADDR_W: register fields of the instruction in ID.
- `ex_rs`, `ex_rt` input, REG_ADDR_W: source fields held in the ID/EX datapath register.
- `ex_zero` input, 1: ALU zero flag of the instruction in EX.
- `ex_alusrc` output, 1: 1 selects the immediate.
- `ex_aluop` output, 2: 00 R-type funct, 01 add, 10 sub, 11 slt.
- `fwd_a`, `fwd_b` output, 2: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
- `mem_memread`, `mem_memwrite` output, 1: data-memory strobes.
- `wb_regwrite` output, 1: register-file write enable.
- `wb_memtoreg` output, 1: 1 selects the ALU result, 0 selects memory data.
- `wb_rfsrc` output, 1: 0 selects the PC+4 link value.
- `wb_dst` output, REG_ADDR_W: write address.
- `pcsrc` output, 2: 00 PC+4, 01 jump, 10 jal, 11 branch target.
- `pc_write`, `ifid_write` output, 1: 0 freezes PC / IF/ID.
- `ifid_flush` output, 1: squashes IF/ID.
- `stall_cnt`, `flush_cnt` output, CNT_W: saturating event counters.

## Operation
- **Decode opcodes:**
  - R=000000, j=010000, jal=011000, beq=100000, bne=101000.
  - addi=000001, slti=010001, lw=011100, sw=011101.
  - Any other opcode decodes to an all-zero control word (NOP).
- **Destination register:**
  - R-type writes `id_rd`.
  - addi, slti and lw write `id_rt`.
  - jal writes LINK_REG.
  - Any write to register 0 has regwrite forced to 0.
- **Control transfer, evaluated from the EX-stage control:**
  - j: pcsrc 01.
  - jal: pcsrc 10.
  - beq: pcsrc 11 when `ex_zero`=1.
  - bne: pcsrc 11 when `ex_zero`=0.
  - Otherwise pcsrc 00.
  - A taken transfer asserts `ifid_flush` and loads a bubble into ID/EX on the next edge. Penalty is 2 cycles.
- **Load-use stall:**
  - Triggered when EX holds lw, its dst ≠ 0, and dst equals `id_rs` or `id_rt`.
  - Response: `pc_write`=0, `ifid_write`=0, and a bubble enters ID/EX.
  - Lasts exactly 1 cycle.
- **Forwarding (applies independently to `fwd_a`/`ex_rs` and `fwd_b`/`ex_rt`):**
  - Select 01 if EX/MEM has regwrite set, dst ≠ 0 and dst equals the source field.
  - Otherwise select 10 on the same condition against MEM/WB.
  - EX/MEM takes priority over MEM/WB.
- **Stall and flush in the same cycle:** flush wins. `pc_write`=1, `ifid_write`=1, `ifid_flush`=1, bubble into ID/EX, and only `flush_cnt` increments.
- **Counters:** +1 per stall cycle and per flush cycle. Each counter saturates at 2^CNT_W−1.

## Timing
- **Pipeline latency:** control decoded in ID appears on the `ex_*` outputs 1 edge later, on `mem_*` 2 edges later and on `wb_*` 3 edges later.
- **Combinational outputs:** `pcsrc`, `ifid_flush`, `pc_write`, `ifid_write` and `fwd_*` are combinational from the stage registers and inputs. There is no extra register stage.
- **Reset:**
  - All pipeline registers clear to bubbles, so every control output is 0.
  - `pcsrc`=00, `pc_write`=1, `ifid_write`=1, `ifid_flush`=0, `fwd_*`=00, counters 0.
  - Reset takes effect immediately, including mid-stall or mid-flush; nothing in flight survives.
- **Bubble handling:** a bubble never triggers a stall, a flush or forwarding.

## Structure
- **Package `mips_pkg`:**
  - Opcode localparams.
  - aluop, pcsrc and fwd encodings.
  - Packed struct `ctrl_t` {regwrite, alusrc, aluop, memread, memwrite, memtoreg, rfsrc, jump, jal, beq, bne}.
- **Sub-module `mips_hazard_unit`:** purely combinational; computes the stall and forwarding selects.
- **Top level:** holds the decoder, the three stage registers, transfer resolution and the counters.

## Test plan
- **Reset mid-stall:** reset during a stall → all outputs at their reset values; the counters, previously nonzero, read 0.
- **Load-use stall:** lw r5 followed by add r6,r5,r1 → one cycle with `pc_write`=0, `ifid_write`=0, `stall_cnt`=1. Then add reaches EX with `fwd_a`=10.
- **Back-to-back forwarding:** addi r2 followed by sub r3,r2,r2 → `fwd_a`=`fwd_b`=01. A write to r0 gives 00.
- **bne taken:** bne with `ex_zero`=0 → `pcsrc`=11, `ifid_flush`=1, following instruction's controls all 0, `flush_cnt`=1. With `ex_zero`=1 → `pcsrc`=00 and no flush.
- **jal:** `pcsrc`=10 and flush. 3 edges later `wb_regwrite`=1, `wb_dst`=31, `wb_rfsrc`=0.
- **Stall and flush together:** beq taken in EX while ID's lw-dependence holds → flush only, `stall_cnt` unchanged. Separately, with CNT_W=2, five flushes → `flush_cnt`=3.

Source files
------------

// File: rtl/mips_pipe_ctrl_pkg.sv
// Shared encodings, control word and opcode decoder for the pipelined MIPS control unit.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b010000;
  localparam logic [5:0] OP_JAL  = 6'b011000;
  localparam logic [5:0] OP_BEQ  = 6'b100000;
  localparam logic [5:0] OP_BNE  = 6'b101000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SLTI = 6'b010001;
  localparam logic [5:0] OP_LW   = 6'b011100;
  localparam logic [5:0] OP_SW   = 6'b011101;

  localparam logic [1:0] ALU_FUNCT = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_SUB   = 2'b10;
  localparam logic [1:0] ALU_SLT   = 2'b11;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_JUMP = 2'b01;
  localparam logic [1:0] PC_JAL  = 2'b10;
  localparam logic [1:0] PC_BR   = 2'b11;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic       alusrc;
    logic [1:0] aluop;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       rfsrc;
    logic       jump;
    logic       jal;
    logic       beq;
    logic       bne;
  } ctrl_t;

  // memtoreg=1 picks the ALU result; rfsrc=0 picks the PC+4 link value.
  function automatic ctrl_t decode(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_R:    begin c.regwrite = 1'b1; c.aluop = ALU_FUNCT; c.memtoreg = 1'b1; c.rfsrc = 1'b1; end
      OP_J:    c.jump = 1'b1;
      OP_JAL:  begin c.regwrite = 1'b1; c.jal = 1'b1; end
      OP_BEQ:  begin c.aluop = ALU_SUB; c.beq = 1'b1; end
      OP_BNE:  begin c.aluop = ALU_SUB; c.bne = 1'b1; end
      OP_ADDI: begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ALU_ADD; c.memtoreg = 1'b1; c.rfsrc = 1'b1; end
      OP_SLTI: begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ALU_SLT; c.memtoreg = 1'b1; c.rfsrc = 1'b1; end
      OP_LW:   begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.aluop = ALU_ADD; c.memread = 1'b1; c.rfsrc = 1'b1; end
      OP_SW:   begin c.alusrc = 1'b1; c.aluop = ALU_ADD; c.memwrite = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_pipe_ctrl_if.sv
// Datapath <-> control-unit bundle: ID/EX fields in, stage controls, selects and counters out.
interface mips_pipe_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [5:0]            id_opcode;
  logic [REG_ADDR_W-1:0] id_rs, id_rt, id_rd;
  logic [REG_ADDR_W-1:0] ex_rs, ex_rt;
  logic                  ex_zero;

  logic                  ex_alusrc;
  logic [1:0]            ex_aluop;
  logic [1:0]            fwd_a, fwd_b;
  logic                  mem_memread, mem_memwrite;
  logic                  wb_regwrite, wb_memtoreg, wb_rfsrc;
  logic [REG_ADDR_W-1:0] wb_dst;
  logic [1:0]            pcsrc;
  logic                  pc_write, ifid_write, ifid_flush;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;

  modport master (
    output id_opcode, id_rs, id_rt, id_rd, ex_rs, ex_rt, ex_zero,
    input  ex_alusrc, ex_aluop, fwd_a, fwd_b, mem_memread, mem_memwrite,
           wb_regwrite, wb_memtoreg, wb_rfsrc, wb_dst, pcsrc,
           pc_write, ifid_write, ifid_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_opcode, id_rs, id_rt, id_rd, ex_rs, ex_rt, ex_zero,
    output ex_alusrc, ex_aluop, fwd_a, fwd_b, mem_memread, mem_memwrite,
           wb_regwrite, wb_memtoreg, wb_rfsrc, wb_dst, pcsrc,
           pc_write, ifid_write, ifid_flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/mips_pipe_ctrl_hazard.sv
// Load-use stall detection and EX operand forwarding selects; purely combinational.
module mips_hazard_unit
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_dst,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  stall,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);
  logic mem_ok, wb_ok;

  // Callers gate the stage controls with their valid bits, so bubbles never match.
  assign stall  = ex_memread && (ex_dst != '0) && ((ex_dst == id_rs) || (ex_dst == id_rt));
  assign mem_ok = mem_regwrite && (mem_dst != '0);
  assign wb_ok  = wb_regwrite && (wb_dst != '0);

  assign fwd_a = (mem_ok && mem_dst == ex_rs) ? FWD_EXMEM :
                 (wb_ok  && wb_dst  == ex_rs) ? FWD_MEMWB : FWD_RF;
  assign fwd_b = (mem_ok && mem_dst == ex_rt) ? FWD_EXMEM :
                 (wb_ok  && wb_dst  == ex_rt) ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/mips_pipe_ctrl.sv
// Pipelined MIPS control: ID decode, ID/EX-EX/MEM-MEM/WB control registers, EX transfer
// resolution, stall/flush generation and saturating event counters.
module mips_pipe_ctrl
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LINK_REG   = 31,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mips_pipe_ctrl_if.slave  bus
);
  localparam int STAGES = 3;
  typedef logic [REG_ADDR_W-1:0] reg_t;

  ctrl_t id_c, idex_c;
  reg_t  id_dst, idex_dst, exmem_dst, memwb_dst;
  logic  exmem_rw, exmem_mr, exmem_mw, exmem_m2r, exmem_rfs;
  logic  memwb_rw, memwb_m2r, memwb_rfs;
  logic [STAGES:1] vld_pipe;
  logic  vld_in, stall, stall_eff, flush;
  logic  ex_jump, ex_jal, ex_br, ex_mr, mem_rw, wb_rw;
  reg_t  ex_dst;
  logic [1:0] pcsrc;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_comb begin
    id_c   = decode(bus.id_opcode);
    id_dst = '0;
    case (bus.id_opcode)
      OP_R:                    id_dst = bus.id_rd;
      OP_ADDI, OP_SLTI, OP_LW: id_dst = bus.id_rt;
      OP_JAL:                  id_dst = reg_t'(LINK_REG);
      default: ;
    endcase
    if (id_dst == '0) id_c.regwrite = 1'b0;
  end

  // Raw control bits flow unconditionally; vld_pipe alone marks a stage as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      idex_c    <= '0;
      idex_dst  <= '0;
      exmem_rw  <= 1'b0; exmem_mr  <= 1'b0; exmem_mw <= 1'b0;
      exmem_m2r <= 1'b0; exmem_rfs <= 1'b0; exmem_dst <= '0;
      memwb_rw  <= 1'b0; memwb_m2r <= 1'b0; memwb_rfs <= 1'b0; memwb_dst <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], vld_in};
      idex_c    <= id_c;
      idex_dst  <= id_dst;
      exmem_rw  <= idex_c.regwrite; exmem_mr  <= idex_c.memread; exmem_mw <= idex_c.memwrite;
      exmem_m2r <= idex_c.memtoreg; exmem_rfs <= idex_c.rfsrc;   exmem_dst <= idex_dst;
      memwb_rw  <= exmem_rw; memwb_m2r <= exmem_m2r; memwb_rfs <= exmem_rfs; memwb_dst <= exmem_dst;
    end
  end

  assign ex_jump = vld_pipe[1] & idex_c.jump;
  assign ex_jal  = vld_pipe[1] & idex_c.jal;
  assign ex_br   = vld_pipe[1] & ((idex_c.beq & bus.ex_zero) | (idex_c.bne & ~bus.ex_zero));
  assign ex_mr   = vld_pipe[1] & idex_c.memread;
  assign ex_dst  = vld_pipe[1] ? idex_dst : '0;
  assign mem_rw  = vld_pipe[2] & exmem_rw;
  assign wb_rw   = vld_pipe[3] & memwb_rw;

  always_comb begin
    pcsrc = PC_SEQ;
    if (ex_jump)     pcsrc = PC_JUMP;
    else if (ex_jal) pcsrc = PC_JAL;
    else if (ex_br)  pcsrc = PC_BR;
  end

  mips_hazard_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .ex_memread   (ex_mr),
    .ex_dst       (ex_dst),
    .id_rs        (bus.id_rs),
    .id_rt        (bus.id_rt),
    .mem_regwrite (mem_rw),
    .mem_dst      (exmem_dst),
    .wb_regwrite  (wb_rw),
    .wb_dst       (memwb_dst),
    .ex_rs        (bus.ex_rs),
    .ex_rt        (bus.ex_rt),
    .stall        (stall),
    .fwd_a        (bus.fwd_a),
    .fwd_b        (bus.fwd_b)
  );

  // A taken transfer squashes the stalled instruction anyway, so flush overrides the stall.
  assign flush     = (pcsrc != PC_SEQ);
  assign stall_eff = stall & ~flush;
  assign vld_in    = ~(stall | flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_eff && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != '1)     flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.pcsrc        = pcsrc;
  assign bus.ifid_flush   = flush;
  assign bus.pc_write     = ~stall_eff;
  assign bus.ifid_write   = ~stall_eff;
  assign bus.ex_alusrc    = vld_pipe[1] & idex_c.alusrc;
  assign bus.ex_aluop     = vld_pipe[1] ? idex_c.aluop : 2'b00;
  assign bus.mem_memread  = vld_pipe[2] & exmem_mr;
  assign bus.mem_memwrite = vld_pipe[2] & exmem_mw;
  assign bus.wb_regwrite  = wb_rw;
  assign bus.wb_memtoreg  = vld_pipe[3] & memwb_m2r;
  assign bus.wb_rfsrc     = vld_pipe[3] & memwb_rfs;
  assign bus.wb_dst       = vld_pipe[3] ? memwb_dst : '0;
  assign bus.stall_cnt    = stall_cnt;
  assign bus.flush_cnt    = flush_cnt;
endmodule
